// File: rtl/parking_exit_if.sv
// Exit-side handshake bundle between the exit sensor/capacity owner and the exit controller.
interface parking_exit_if;
    logic        exit;
    logic [2:0]  slot_id;
    logic [7:0]  parking_capacity;
    logic        release_valid;
    logic [7:0]  release_mask;
    logic        exit_ack;
    logic        exit_error;
    logic        gate_open;
    logic        busy;
    logic [15:0] exit_count;

    modport master (
        output exit, slot_id, parking_capacity,
        input  release_valid, release_mask, exit_ack, exit_error, gate_open, busy, exit_count
    );

    modport slave (
        input  exit, slot_id, parking_capacity,
        output release_valid, release_mask, exit_ack, exit_error, gate_open, busy, exit_count
    );
endinterface

// File: rtl/parking_exit_controller.sv
// Exit-side slot release: validates an exit against the free-slot bitmap, strobes a
// one-hot release, times the exit gate and keeps a saturating count of completed exits.
module parking_exit_controller #(
    parameter int unsigned GATE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    parking_exit_if.slave  bus
);
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned CAP_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMR_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RELEASE,
        ERROR,
        OPEN,
        WAIT_CLEAR
    } state_e;

    state_e             state_q;
    logic               exit_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [TMR_W-1:0]   timer_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               release_valid_q;
    logic [CAP_W-1:0]   release_mask_q;
    logic               exit_ack_q;
    logic               exit_error_q;
    logic               gate_open_q;
    logic               busy_q;
    logic               request_c;

    assign request_c = bus.exit & ~exit_q;
    assign count_d   = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    // Outputs are registered alongside the state so every pulse aligns with its state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            exit_q          <= 1'b1;
            slot_q          <= '0;
            timer_q         <= '0;
            count_q         <= '0;
            release_valid_q <= 1'b0;
            release_mask_q  <= '0;
            exit_ack_q      <= 1'b0;
            exit_error_q    <= 1'b0;
            gate_open_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            exit_q          <= bus.exit;
            release_valid_q <= 1'b0;
            release_mask_q  <= '0;
            exit_ack_q      <= 1'b0;
            exit_error_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (request_c) begin
                        slot_q  <= bus.slot_id;
                        state_q <= CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (bus.parking_capacity[slot_q]) begin
                        state_q      <= ERROR;
                        exit_error_q <= 1'b1;
                    end else begin
                        state_q         <= RELEASE;
                        release_valid_q <= 1'b1;
                        exit_ack_q      <= 1'b1;
                        release_mask_q  <= CAP_W'(1) << slot_q;
                    end
                end
                RELEASE: begin
                    state_q     <= OPEN;
                    gate_open_q <= 1'b1;
                    timer_q     <= TMR_W'(GATE_CYCLES - 1);
                    count_q     <= count_d;
                end
                ERROR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                OPEN: begin
                    if (timer_q == '0) begin
                        state_q     <= WAIT_CLEAR;
                        gate_open_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                WAIT_CLEAR: begin
                    if (!bus.exit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gate_open_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.release_valid = release_valid_q;
    assign bus.release_mask  = release_mask_q;
    assign bus.exit_ack      = exit_ack_q;
    assign bus.exit_error    = exit_error_q;
    assign bus.gate_open     = gate_open_q;
    assign bus.busy          = busy_q;
    assign bus.exit_count    = count_q;
endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for parking_exit_controller: table of single exits plus multi-cycle sequences.
module tb_parking_exit_controller;
    localparam int unsigned GATE = 16;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;
    int   rv_pulses;
    int   bad_mask;
    logic [15:0] exp_count;

    parking_exit_if bus();

    parking_exit_controller #(.GATE_CYCLES(GATE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.release_valid === 1'b1) rv_pulses++;
        if (bus.release_valid !== 1'b1 && bus.release_mask !== 8'h00) bad_mask++;
    end

    typedef struct {
        logic [7:0] cap;
        logic [2:0] slot;
        logic       exp_err;
        logic [7:0] exp_mask;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Single exit request; exit is dropped right after the rise so WAIT_CLEAR is one cycle.
    task automatic run_req(input logic [7:0] cap, input logic [2:0] slot,
                           input logic exp_err, input logic [7:0] exp_mask);
        int n;
        bus.parking_capacity = cap;
        bus.exit = 1'b0;
        tick();
        bus.slot_id = slot;
        bus.exit = 1'b1;
        tick();
        check("busy_at_E0", 32'(bus.busy), 32'd1);
        bus.exit = 1'b0;
        tick();
        check("release_valid_E1", 32'(bus.release_valid), 32'(!exp_err));
        check("release_mask_E1", 32'(bus.release_mask), 32'(exp_mask));
        check("exit_ack_E1", 32'(bus.exit_ack), 32'(!exp_err));
        check("exit_error_E1", 32'(bus.exit_error), 32'(exp_err));
        if (!exp_err && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        tick();
        check("release_valid_E2", 32'(bus.release_valid), 32'd0);
        check("exit_count_E2", 32'(bus.exit_count), 32'(exp_count));
        check("gate_open_E2", 32'(bus.gate_open), 32'(!exp_err));
        if (!exp_err) begin
            n = 1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bus.gate_open !== 1'b1) break;
                n++;
            end
            check("gate_cycles", 32'(n), 32'(GATE));
            check("busy_wait_clear", 32'(bus.busy), 32'd1);
        end
        tick();
        check("busy_idle_again", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int n;
        int lowcnt;
        int rv0;

        total = 0;
        passed = 0;
        rv_pulses = 0;
        bad_mask = 0;
        exp_count = 16'h0000;
        vecs[0] = '{8'hFF, 3'd3, 1'b1, 8'h00};
        vecs[1] = '{8'hFE, 3'd0, 1'b0, 8'h01};
        vecs[2] = '{8'h7F, 3'd7, 1'b0, 8'h80};
        vecs[3] = '{8'hF7, 3'd3, 1'b0, 8'h08};
        vecs[4] = '{8'h08, 3'd3, 1'b1, 8'h00};
        vecs[5] = '{8'h00, 3'd2, 1'b0, 8'h04};

        // Reset with exit held high; no request may follow.
        reset_n = 1'b0;
        bus.exit = 1'b1;
        bus.slot_id = 3'd0;
        bus.parking_capacity = 8'h00;
        tick();
        tick();
        check("rst_release_valid", 32'(bus.release_valid), 32'd0);
        check("rst_gate_open", 32'(bus.gate_open), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_exit_count", 32'(bus.exit_count), 32'd0);
        check("rst_exit_error", 32'(bus.exit_error), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("no_req_held_exit", 32'(bus.busy), 32'd0);

        // Occupied release of slot 5 with a second request toggled during OPEN.
        bus.exit = 1'b0;
        tick();
        bus.slot_id = 3'd5;
        bus.exit = 1'b1;
        tick();
        check("A_busy_E0", 32'(bus.busy), 32'd1);
        tick();
        check("A_release_valid", 32'(bus.release_valid), 32'd1);
        check("A_release_mask", 32'(bus.release_mask), 32'h20);
        tick();
        check("A_count", 32'(bus.exit_count), 32'd1);
        check("A_gate_E2", 32'(bus.gate_open), 32'd1);
        exp_count = 16'd1;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.gate_open !== 1'b1) break;
            n++;
            if (i == 3) bus.exit = 1'b0;
            if (i == 5) begin
                bus.slot_id = 3'd1;
                bus.exit = 1'b1;
            end
            if (i == 7) bus.exit = 1'b0;
        end
        check("A_gate_cycles", 32'(n), 32'(GATE));
        check("A_busy_wait_clear", 32'(bus.busy), 32'd1);
        tick();
        check("A_busy_idle", 32'(bus.busy), 32'd0);
        check("A_single_release", 32'(rv_pulses), 32'd1);
        check("A_count_after", 32'(bus.exit_count), 32'd1);

        for (int v = 0; v < 6; v++)
            run_req(vecs[v].cap, vecs[v].slot, vecs[v].exp_err, vecs[v].exp_mask);

        // Vehicle lingers: exit held high well past gate close.
        bus.parking_capacity = 8'h00;
        bus.exit = 1'b0;
        tick();
        bus.slot_id = 3'd6;
        bus.exit = 1'b1;
        tick();
        tick();
        check("L_release_mask", 32'(bus.release_mask), 32'h40);
        tick();
        exp_count = exp_count + 16'd1;
        check("L_count", 32'(bus.exit_count), 32'(exp_count));
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.gate_open !== 1'b1) break;
            n++;
        end
        check("L_gate_cycles", 32'(n), 32'(GATE));
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy !== 1'b1) lowcnt++;
            if (bus.gate_open !== 1'b0) lowcnt++;
        end
        check("L_busy_held", 32'(lowcnt), 32'd0);
        bus.exit = 1'b0;
        tick();
        check("L_busy_released", 32'(bus.busy), 32'd0);

        // Reset at cycle 5 of OPEN.
        bus.exit = 1'b0;
        tick();
        bus.slot_id = 3'd2;
        bus.exit = 1'b1;
        tick();
        bus.exit = 1'b0;
        tick();
        tick();
        check("R_gate_E2", 32'(bus.gate_open), 32'd1);
        tick();
        tick();
        tick();
        tick();
        check("R_gate_cycle5", 32'(bus.gate_open), 32'd1);
        reset_n = 1'b0;
        tick();
        check("R_gate_off", 32'(bus.gate_open), 32'd0);
        check("R_count_zero", 32'(bus.exit_count), 32'd0);
        check("R_busy_zero", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        exp_count = 16'h0000;
        rv0 = rv_pulses;
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gate_open !== 1'b0 || bus.busy !== 1'b0) lowcnt++;
        end
        check("R_stays_idle", 32'(lowcnt), 32'd0);
        check("R_no_release", 32'(rv_pulses - rv0), 32'd0);

        // Saturation from FFFE.
        force dut.count_q = 16'hFFFE;
        tick();
        release dut.count_q;
        tick();
        check("S_preload", 32'(bus.exit_count), 32'hFFFE);
        exp_count = 16'hFFFE;
        rv0 = rv_pulses;
        run_req(8'h00, 3'd4, 1'b0, 8'h10);
        check("S_first", 32'(bus.exit_count), 32'hFFFF);
        run_req(8'h00, 3'd0, 1'b0, 8'h01);
        check("S_second", 32'(bus.exit_count), 32'hFFFF);
        check("S_two_releases", 32'(rv_pulses - rv0), 32'd2);

        check("mask_zero_when_idle", 32'(bad_mask), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
